vga_timing_out: RTL and testbench

//  Downstream display stage of the Pong pipeline: 640x480@60 Hz timing generator and pixel output.

---
 rtl/vga_timing_out_pkg.sv | 36 +++
 rtl/vga_delay_line.sv | 39 +++
 rtl/vga_timing_out.sv | 160 ++++++++++++++++
 tb/tb_vga_timing_out.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_out_pkg.sv
// Shared timing constants and types for the VGA output stage.
package vga_timing_out_pkg;

    // 640x480@60 Hz horizontal timing, in pixel ticks
    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int H_TOTAL    = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    // 640x480@60 Hz vertical timing, in lines
    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;
    localparam int V_TOTAL    = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Ticks from X_pix/Y_pix update to matching pixel_color at the input
    localparam int PIPE_DLY_DEF = 2;

    // Colour field offsets inside pixel_color: {B, G, R}
    localparam int R_LSB = 0;
    localparam int G_LSB = 4;
    localparam int B_LSB = 8;

    // Sync/blank bundle that travels through the alignment delay line
    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } sync_bus_t;

    // Idle value: blanked, both syncs inactive (high)
    localparam sync_bus_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// N-stage, W-bit shift register that advances only when en is high.
module vga_delay_line #(
    parameter int N = 2,
    parameter int W = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [N-1:0][W-1:0] stage_q;
    logic [N-1:0][W-1:0] stage_d;

    // Shift every stage by one position on each enable
    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = d;
            for (int i = 1; i < N; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Stage registers, reset to the idle value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= {N{RST_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[N-1];

endmodule

// File: rtl/vga_timing_out.sv
// VGA timing generator and pin stage: pixel tick divider, X/Y counters,
// sync generation and colour/sync alignment to the VGA pins.
module vga_timing_out
    import vga_timing_out_pkg::*;
#(
    parameter int H_VIS    = H_VIS_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_VIS    = V_VIS_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int PIPE_DLY = PIPE_DLY_DEF
) (
    input  logic        CLK_50,
    input  logic        RESET_N,
    input  logic [11:0] pixel_color,
    output logic [9:0]  X_pix,
    output logic [9:0]  Y_pix,
    output logic        H_visible,
    output logic        V_visible,
    output logic        pixel_clk,
    output logic        pixel_tick,
    output logic        frame_start,
    output logic [3:0]  VGA_BUS_R,
    output logic [3:0]  VGA_BUS_G,
    output logic [3:0]  VGA_BUS_B,
    output logic        VGA_HS,
    output logic        VGA_VS
);

    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic        toggle_q, toggle_d;
    logic        tick_q, tick_d;
    logic        tick_en;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        h_vis_q, h_vis_d;
    logic        v_vis_q, v_vis_d;
    logic        fs_q, fs_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    sync_bus_t   sync_raw;
    sync_bus_t   sync_dly;

    // Everything advances on the edge where the tick strobe is raised,
    // so new counter values and pixel_tick appear in the same cycle.
    assign tick_en = ~toggle_q;

    // Divide CLK_50 by two: toggle flips every cycle, strobe follows it
    always_comb begin
        toggle_d = ~toggle_q;
        tick_d   = tick_en;
    end

    // Pixel/line counters with wrap, frame pulse and look-ahead visible flags
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        fs_d = 1'b0;
        if (tick_en) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        h_vis_d = (x_d < H_VIS_L);
        v_vis_d = (y_d < V_VIS_L);
    end

    // Undelayed syncs and blank derived from the current counters
    always_comb begin
        sync_raw     = SYNC_IDLE;
        sync_raw.hs  = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
        sync_raw.vs  = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));
        sync_raw.vis = h_vis_q & v_vis_q;
    end

    vga_delay_line #(
        .N       (PIPE_DLY),
        .W       ($bits(sync_bus_t)),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk   (CLK_50),
        .rst_n (RESET_N),
        .en    (tick_en),
        .d     (sync_raw),
        .q     (sync_dly)
    );

    // Pin stage: colour gated by the delayed blank so porches stay black
    always_comb begin
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (tick_en) begin
            rgb_d = sync_dly.vis ? pixel_color : 12'h000;
            hs_d  = sync_dly.hs;
            vs_d  = sync_dly.vs;
        end
    end

    // All state registers; reset puts outputs in the blanked, sync-idle state
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            toggle_q <= 1'b0;
            tick_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            h_vis_q  <= 1'b1;
            v_vis_q  <= 1'b1;
            fs_q     <= 1'b0;
            rgb_q    <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
        end else begin
            toggle_q <= toggle_d;
            tick_q   <= tick_d;
            x_q      <= x_d;
            y_q      <= y_d;
            h_vis_q  <= h_vis_d;
            v_vis_q  <= v_vis_d;
            fs_q     <= fs_d;
            rgb_q    <= rgb_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
        end
    end

    assign X_pix       = x_q;
    assign Y_pix       = y_q;
    assign H_visible   = h_vis_q;
    assign V_visible   = v_vis_q;
    assign pixel_clk   = toggle_q;
    assign pixel_tick  = tick_q;
    assign frame_start = fs_q;
    assign VGA_BUS_R   = rgb_q[R_LSB +: 4];
    assign VGA_BUS_G   = rgb_q[G_LSB +: 4];
    assign VGA_BUS_B   = rgb_q[B_LSB +: 4];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: a full 640x480 instance and a miniature-timing
// instance (so frame wrap and vertical sync are reached quickly), both
// checked against a counter-arithmetic model through expected queues.
`timescale 1ns/1ps
module tb_vga_timing_out;

    // Full-size timing
    localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VV = 480, A_VF = 10, A_VS = 2,  A_VB = 33, A_D = 2;
    localparam int A_HT = A_HV + A_HF + A_HS + A_HB;
    localparam int A_VT = A_VV + A_VF + A_VS + A_VB;
    // Miniature timing
    localparam int B_HV = 8, B_HF = 2, B_HS = 3, B_HB = 2;
    localparam int B_VV = 4, B_VF = 1, B_VS = 2, B_VB = 1, B_D = 3;
    localparam int B_HT = B_HV + B_HF + B_HS + B_HB;
    localparam int B_VT = B_VV + B_VF + B_VS + B_VB;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hvis;
        logic        vvis;
        logic        fs;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } rec_t;

    localparam rec_t RST_REC = '{x: 10'd0, y: 10'd0, hvis: 1'b1, vvis: 1'b1,
                                 fs: 1'b0, rgb: 12'h000, hs: 1'b1, vs: 1'b1};

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    logic [11:0] col_a, col_b;
    logic [9:0]  a_x, a_y, b_x, b_y;
    logic        a_hvis, a_vvis, a_pclk, a_tick, a_fs, a_hs, a_vs;
    logic        b_hvis, b_vvis, b_pclk, b_tick, b_fs, b_hs, b_vs;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    rec_t        got_a, got_b;

    assign got_a = {a_x, a_y, a_hvis, a_vvis, a_fs, a_b, a_g, a_r, a_hs, a_vs};
    assign got_b = {b_x, b_y, b_hvis, b_vvis, b_fs, b_b, b_g, b_r, b_hs, b_vs};

    vga_timing_out u_dut_a (
        .CLK_50(clk), .RESET_N(rst_n), .pixel_color(col_a),
        .X_pix(a_x), .Y_pix(a_y), .H_visible(a_hvis), .V_visible(a_vvis),
        .pixel_clk(a_pclk), .pixel_tick(a_tick), .frame_start(a_fs),
        .VGA_BUS_R(a_r), .VGA_BUS_G(a_g), .VGA_BUS_B(a_b),
        .VGA_HS(a_hs), .VGA_VS(a_vs)
    );

    vga_timing_out #(
        .H_VIS(B_HV), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_VIS(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .PIPE_DLY(B_D)
    ) u_dut_b (
        .CLK_50(clk), .RESET_N(rst_n), .pixel_color(col_b),
        .X_pix(b_x), .Y_pix(b_y), .H_visible(b_hvis), .V_visible(b_vvis),
        .pixel_clk(b_pclk), .pixel_tick(b_tick), .frame_start(b_fs),
        .VGA_BUS_R(b_r), .VGA_BUS_G(b_g), .VGA_BUS_B(b_b),
        .VGA_HS(b_hs), .VGA_VS(b_vs)
    );

    // ---------------- scoreboard state ----------------
    rec_t exp_a_q[$];
    rec_t exp_b_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Colour returned by the upstream model for a pixel: line 0 mod 3 carries
    // the X count, line 1 mod 3 is white, line 2 mod 3 is a mixed pattern.
    function automatic logic [11:0] col_of(int x, int y);
        logic [9:0] xv;
        logic [9:0] yv;
        xv = 10'(x);
        yv = 10'(y);
        case (y % 3)
            0:       return {2'b00, xv};
            1:       return 12'hFFF;
            default: return {xv[3:0] ^ 4'h5, yv[3:0], xv[7:4] | 4'h1};
        endcase
    endfunction

    function automatic logic [11:0] drive_col(int p, int ht, int vt);
        if (p < 0) return 12'h000;
        return col_of(p % ht, (p / ht) % vt);
    endfunction

    // Expected outputs at tick t: counters from t, pins from pixel t-(d+1)
    function automatic rec_t model(int t, int d, int hv, int hf, int hsy, int hb,
                                   int vv, int vf, int vsy, int vb);
        int   ht, vt, p, px, py;
        rec_t r;
        ht     = hv + hf + hsy + hb;
        vt     = vv + vf + vsy + vb;
        r.x    = 10'(t % ht);
        r.y    = 10'((t / ht) % vt);
        r.hvis = (t % ht) < hv;
        r.vvis = ((t / ht) % vt) < vv;
        r.fs   = (t % (ht * vt)) == 0;
        p      = t - (d + 1);
        if (p < 0) begin
            r.rgb = 12'h000;
            r.hs  = 1'b1;
            r.vs  = 1'b1;
        end else begin
            px    = p % ht;
            py    = (p / ht) % vt;
            r.rgb = (px < hv && py < vv) ? col_of(px, py) : 12'h000;
            r.hs  = !(px >= hv + hf && px < hv + hf + hsy);
            r.vs  = !(py >= vv + vf && py < vv + vf + vsy);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_rec(input string name, input rec_t got, input rec_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got x=%0d y=%0d hv=%b vv=%b fs=%b rgb=%h hs=%b vs=%b expected x=%0d y=%0d hv=%b vv=%b fs=%b rgb=%h hs=%b vs=%b",
                     name, got.x, got.y, got.hvis, got.vvis, got.fs, got.rgb, got.hs, got.vs,
                     exp.x, exp.y, exp.hvis, exp.vvis, exp.fs, exp.rgb, exp.hs, exp.vs);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (a_tick === 1'b1) begin
            if (exp_a_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_unexpected_tick: got tick with x=%0d expected no tick", a_x);
            end else begin
                check_rec("a_pins", got_a, exp_a_q.pop_front());
            end
        end
        if (b_tick === 1'b1) begin
            if (exp_b_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_unexpected_tick: got tick with x=%0d expected no tick", b_x);
            end else begin
                check_rec("b_pins", got_b, exp_b_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset(input string tag);
        check_rec({tag, "_a"}, got_a, RST_REC);
        check_rec({tag, "_b"}, got_b, RST_REC);
        chk({tag, "_a_tick_clk"}, {a_tick, a_pclk}, 2'b00);
        chk({tag, "_b_tick_clk"}, {b_tick, b_pclk}, 2'b00);
    endtask

    // Called at a negedge while in reset: queue tick 1 and release
    task automatic start_run();
        col_a = 12'h000;
        col_b = 12'h000;
        exp_a_q.push_back(model(1, A_D, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB));
        exp_b_q.push_back(model(1, B_D, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB));
        rst_n = 1'b1;
    endtask

    // Per tick: drive colour for the pixel due next tick, queue its expected pins
    task automatic run_ticks(input int n);
        for (int t = 1; t <= n; t++) begin
            @(negedge clk);
            chk("a_tick_hi", {a_tick, a_pclk}, 2'b11);
            chk("b_tick_hi", {b_tick, b_pclk}, 2'b11);
            col_a = drive_col(t - A_D, A_HT, A_VT);
            col_b = drive_col(t - B_D, B_HT, B_VT);
            exp_a_q.push_back(model(t + 1, A_D, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB));
            exp_b_q.push_back(model(t + 1, B_D, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB));
            @(negedge clk);
            chk("a_tick_lo", {a_tick, a_pclk}, 2'b00);
            chk("b_tick_lo", {b_tick, b_pclk}, 2'b00);
        end
        // let the monitor consume the last queued tick
        @(posedge clk);
        #2;
        chk("a_queue_drained", 64'(exp_a_q.size()), 64'd0);
        chk("b_queue_drained", 64'(exp_b_q.size()), 64'd0);
        exp_a_q.delete();
        exp_b_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        col_a = 12'h000;
        col_b = 12'h000;
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check_reset("reset_hold");

        // Two full lines plus change on the large instance, many frames on the small one
        start_run();
        run_ticks(1700);

        // Mid-frame reset: outputs must drop to reset values before any clock edge
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("reset_async");
        repeat (3) @(negedge clk);
        check_reset("reset_mid_hold");

        // Restart: counts resume from X=1 and the new frame wraps on schedule
        start_run();
        run_ticks(900);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
